// File: rtl/grn_output_arbiter.sv
// grn_output_arbiter
//
// Merges the output FIFOs of NUM_CORES regulator_network cores onto a single
// valid/ready stream. Cores are granted round-robin. Each word carries the
// index of the core that produced it. all_done rises once every core has
// reported task_done and every output FIFO has been drained.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   start          one-cycle pulse that begins a collection run (ignored while busy)
//   core_has_data  per-core "output FIFO not empty"
//   core_data      per-core FIFO read data, core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   core_task_done per-core task_done
//   core_read_en   per-core FIFO read strobe, one-hot or zero
//   out_valid      out_data / out_core_id hold a word
//   out_ready      downstream accepts the word
//   out_data       merged result word
//   out_core_id    index of the source core
//   busy           a run is in progress
//   all_done       run complete; held until the next start

module grn_output_arbiter #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned DATA_WIDTH = 246,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_CORES-1:0]            core_has_data,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_data,
  input  logic [NUM_CORES-1:0]            core_task_done,
  output logic [NUM_CORES-1:0]            core_read_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ID_WIDTH-1:0]             out_core_id,
  output logic                            busy,
  output logic                            all_done
);

  // Pointer width stays at least 1 so a single-core build still has a legal vector.
  localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StArb, StRead, StHold} state_e;

  state_e                 state_q;
  logic [PtrW-1:0]        ptr_q;
  logic [PtrW-1:0]        sel_q;
  logic [NUM_CORES-1:0]   done_sticky_q;

  logic                   hit_hi;
  logic                   hit_lo;
  logic [PtrW-1:0]        pick_hi;
  logic [PtrW-1:0]        pick_lo;
  logic                   found;
  logic [PtrW-1:0]        pick;

  // Round-robin search starting just above ptr_q. Scanning downward leaves the
  // lowest matching index in each half; the half above ptr_q wins over the
  // wrapped half, which yields "first set bit from ptr+1 upward, modulo N".
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (core_has_data[i]) begin
        if (i > int'(ptr_q)) begin
          hit_hi  = 1'b1;
          pick_hi = PtrW'(i);
        end else begin
          hit_lo  = 1'b1;
          pick_lo = PtrW'(i);
        end
      end
    end
    found = hit_hi | hit_lo;
    pick  = hit_hi ? pick_hi : pick_lo;
  end

  // The read strobe must be qualified by has_data in the very cycle it is
  // asserted, so it is decoded from the current state rather than registered.
  always_comb begin
    core_read_en = '0;
    if (state_q == StArb && found) begin
      core_read_en[pick] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      ptr_q         <= PtrW'(NUM_CORES - 1);
      sel_q         <= '0;
      done_sticky_q <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_core_id   <= '0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
    end else begin
      // Done flags accumulate for the whole run; a core that reports done while
      // its FIFO still holds words is drained before the run can finish.
      if (state_q != StIdle) begin
        done_sticky_q <= done_sticky_q | core_task_done;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StArb;
            done_sticky_q <= '0;
            all_done      <= 1'b0;
            ptr_q         <= PtrW'(NUM_CORES - 1);
            busy          <= 1'b1;
          end
        end

        StArb: begin
          if (found) begin
            sel_q   <= pick;
            state_q <= StRead;
          end else if (&done_sticky_q) begin
            all_done <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
        end

        // FIFO read latency is one cycle, so the selected slice is valid now.
        StRead: begin
          out_data    <= core_data[sel_q*DATA_WIDTH +: DATA_WIDTH];
          out_core_id <= ID_WIDTH'(sel_q);
          out_valid   <= 1'b1;
          state_q     <= StHold;
        end

        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr_q     <= sel_q;
            state_q   <= StArb;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_output_arbiter.sv
module tb_grn_output_arbiter;

  localparam int NC    = 4;
  localparam int DW    = 246;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NC-1:0]     core_has_data;
  logic [NC*DW-1:0]  core_data;
  logic [NC-1:0]     core_task_done;
  logic [NC-1:0]     core_read_en;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_core_id;
  logic              busy;
  logic              all_done;

  // Single-core build
  logic              one_start;
  logic [0:0]        one_has;
  logic [7:0]        one_data;
  logic [0:0]        one_task_done;
  logic [0:0]        one_rd;
  logic              one_valid;
  logic              one_ready;
  logic [7:0]        one_out;
  logic [0:0]        one_id;
  logic              one_busy;
  logic              one_all_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grn_output_arbiter #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ID_WIDTH(IW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .core_has_data(core_has_data),
    .core_data(core_data), .core_task_done(core_task_done), .core_read_en(core_read_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_core_id(out_core_id), .busy(busy), .all_done(all_done)
  );

  grn_output_arbiter #(.NUM_CORES(1), .DATA_WIDTH(8), .ID_WIDTH(1)) u_one (
    .clk(clk), .rst(rst), .start(one_start), .core_has_data(one_has),
    .core_data(one_data), .core_task_done(one_task_done), .core_read_en(one_rd),
    .out_valid(one_valid), .out_ready(one_ready), .out_data(one_out),
    .out_core_id(one_id), .busy(one_busy), .all_done(one_all_done)
  );

  // Core output FIFO models: written by the stimulus, popped on read_en with
  // one cycle of read latency.
  logic [DW-1:0] mem [NC][DEPTH];
  int            wr_cnt [NC];
  int            rd_cnt [NC];
  logic [DW-1:0] dout [NC];
  logic          flush;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      core_has_data[i]      = (rd_cnt[i] != wr_cnt[i]);
      core_data[i*DW +: DW] = dout[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (flush) begin
        rd_cnt[i] <= wr_cnt[i];
      end else if (core_read_en[i] && core_has_data[i]) begin
        dout[i]   <= mem[i][rd_cnt[i] % DEPTH];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  int one_wr = 0;
  int one_rd_cnt = 0;
  assign one_has = (one_rd_cnt != one_wr);
  always @(posedge clk) begin
    if (one_rd[0] && one_has[0]) begin
      one_data   <= 8'hA0 + 8'(one_rd_cnt);
      one_rd_cnt <= one_rd_cnt + 1;
    end
  end

  // Reference model state: words queued per core, not yet granted.
  int cnt [NC];
  int mrd [NC];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("rd_legal", DW'(($onehot0(core_read_en) &&
                          ((core_read_en & ~core_has_data) == '0)) ? 1 : 0), DW'(1));
  endtask

  task automatic push(input int c, input logic [DW-1:0] w);
    mem[c][wr_cnt[c] % DEPTH] = w;
    wr_cnt[c]++;
    cnt[c]++;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [255:0] t = '0;
    for (int k = 0; k < 8; k++) t = {t[223:0], 32'($urandom)};
    return t[DW-1:0];
  endfunction

  // One collection run; expected grant order follows the round-robin rule
  // computed over the per-core word counts.
  task automatic run_words(input int hold_lo, input int hold_hi, input bit done_early,
                           input bit mid_start);
    int mp, total, total0, c, prev_cyc, gap_exp, hold, n;
    logic [DW-1:0] w;
    core_task_done = done_early ? '1 : '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", DW'(busy), DW'(1));
    check("start_clr_done", DW'(all_done), DW'(0));
    mp = NC - 1;
    total = 0;
    for (int i = 0; i < NC; i++) total += cnt[i];
    total0 = total;
    prev_cyc = -1;
    gap_exp = 3;
    while (total > 0) begin
      c = -1;
      for (int k = 1; k <= NC; k++) begin
        if (c < 0 && cnt[(mp + k) % NC] > 0) c = (mp + k) % NC;
      end
      cnt[c]--;
      total--;
      mp = c;
      w = mem[c][mrd[c] % DEPTH];
      mrd[c]++;
      n = 0;
      while (core_read_en == '0 && n < 40) begin
        tick();
        n++;
      end
      check("grant", DW'(core_read_en), DW'(1) << c);
      if (prev_cyc >= 0) check("gap", DW'(cyc - prev_cyc), DW'(gap_exp));
      prev_cyc = cyc;
      hold = int'($urandom_range(hold_hi, hold_lo));
      if (hold > 0) out_ready = 1'b0;
      tick();
      check("read_rd_en", DW'(core_read_en), DW'(0));
      check("read_valid", DW'(out_valid), DW'(0));
      if (mid_start) start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_valid", DW'(out_valid), DW'(1));
      check("core_id", DW'(out_core_id), DW'(c));
      check("data", out_data, w);
      check("hold_busy", DW'(busy), DW'(1));
      check("hold_not_done", DW'(all_done), DW'(0));
      for (int h = 0; h < hold; h++) begin
        tick();
        check("stall_valid", DW'(out_valid), DW'(1));
        check("stall_data", out_data, w);
        check("stall_id", DW'(out_core_id), DW'(c));
        check("stall_rd_en", DW'(core_read_en), DW'(0));
      end
      out_ready = 1'b1;
      tick();
      check("accepted", DW'(out_valid), DW'(0));
      gap_exp = 3 + hold;
    end
    if (!done_early) begin
      repeat (3) tick();
      check("wait_done", DW'(all_done), DW'(0));
      check("wait_busy", DW'(busy), DW'(1));
      core_task_done = '1;
    end
    n = 0;
    while (!all_done && n < 20) begin
      tick();
      n++;
    end
    check("all_done", DW'(all_done), DW'(1));
    check("busy_fall", DW'(busy), DW'(0));
    if (done_early && total0 > 0) check("done_latency", DW'(n), DW'(1));
    tick();
    check("done_held", DW'(all_done), DW'(1));
  endtask

  initial begin
    int n;
    rst            = 1'b0;
    start          = 1'b0;
    out_ready      = 1'b1;
    core_task_done = '0;
    flush          = 1'b0;
    one_start      = 1'b0;
    one_ready      = 1'b1;
    one_task_done  = 1'b0;
    repeat (3) tick();
    check("rst_valid", DW'(out_valid), DW'(0));
    check("rst_data", out_data, '0);
    check("rst_id", DW'(out_core_id), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(all_done), DW'(0));
    check("rst_rd_en", DW'(core_read_en), DW'(0));
    rst = 1'b1;
    tick();

    // One word per core, done arrives after draining
    for (int i = 0; i < NC; i++) push(i, rand_word());
    run_words(0, 0, 1'b0, 1'b0);

    // Core 2 holds three words: fairness 0,1,2,3,2,2
    for (int i = 0; i < NC; i++) push(i, rand_word());
    push(2, rand_word());
    push(2, rand_word());
    run_words(0, 0, 1'b1, 1'b0);

    // Backpressure: ten stall cycles on a word from core 1
    push(1, DW'(12'h3A5));
    run_words(10, 10, 1'b1, 1'b0);

    // Done arrives early while cores 0 and 3 hold two words; start pulses mid-run
    push(0, rand_word());
    push(3, rand_word());
    push(0, rand_word());
    push(3, rand_word());
    run_words(0, 1, 1'b1, 1'b1);

    // Reset while holding a word
    push(1, rand_word());
    push(2, rand_word());
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (core_read_en == '0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("pre_rst_valid", DW'(out_valid), DW'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_valid", DW'(out_valid), DW'(0));
    check("arst_done", DW'(all_done), DW'(0));
    check("arst_busy", DW'(busy), DW'(0));
    check("arst_data", out_data, '0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_rd_en", DW'(core_read_en), DW'(0));
      check("post_rst_busy", DW'(busy), DW'(0));
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < NC; i++) begin
      cnt[i] = 0;
      mrd[i] = wr_cnt[i];
    end

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NC; i++) begin
        int m = int'($urandom_range(3, 0));
        for (int j = 0; j < m; j++) push(i, rand_word());
      end
      run_words(0, 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Single-core build: three words from core 0
    one_task_done = 1'b1;
    one_wr = 3;
    one_start = 1'b1;
    tick();
    one_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!one_valid && n < 20) begin
        tick();
        n++;
      end
      check("one_valid", DW'(one_valid), DW'(1));
      check("one_id", DW'(one_id), DW'(0));
      check("one_data", DW'(one_out), DW'(8'hA0 + 8'(k)));
      tick();
    end
    n = 0;
    while (!one_all_done && n < 20) begin
      tick();
      n++;
    end
    check("one_all_done", DW'(one_all_done), DW'(1));
    check("one_busy", DW'(one_busy), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
